// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: load-use stall, branch squash and
// memory freeze with timeout, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             IFID_RS1use_i,
  input  logic             IFID_RS2use_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             Branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_write_o,
  output logic             IDEX_bubble_o,
  output logic             EXMEM_write_o,
  output logic             MEMWB_bubble_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    MWAIT,
    ERR
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              freeze;
  logic              load_use;
  logic              flush_act;
  logic              stall_act;

  assign load_use = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                    ((IFID_RS1use_i && (IFID_RS1addr_i == IDEX_RDaddr_i)) ||
                     (IFID_RS2use_i && (IFID_RS2addr_i == IDEX_RDaddr_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    freeze    = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          freeze    = 1'b1;
          state_nxt = MWAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MWAIT: begin
        // An ack on the last allowed cycle still completes the access.
        if (mem_ack_i) begin
          state_nxt = RUN;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERR;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  assign flush_act = !freeze && Branch_taken_i;
  assign stall_act = !freeze && !Branch_taken_i && load_use;

  always_comb begin
    PC_write_o     = 1'b1;
    IFID_write_o   = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_write_o   = 1'b1;
    IDEX_bubble_o  = 1'b0;
    EXMEM_write_o  = 1'b1;
    MEMWB_bubble_o = 1'b0;
    if (rst_i) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IDEX_write_o   = 1'b0;
      IDEX_bubble_o  = 1'b1;
      EXMEM_write_o  = 1'b0;
      MEMWB_bubble_o = 1'b1;
    end else if (freeze) begin
      // MEM/WB is bubbled so the held instruction does not write back twice.
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IDEX_write_o   = 1'b0;
      EXMEM_write_o  = 1'b0;
      MEMWB_bubble_o = 1'b1;
    end else if (flush_act) begin
      IFID_flush_o  = 1'b1;
      IDEX_bubble_o = 1'b1;
    end else if (stall_act) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
    end
  end

  assign mem_err_o = (state == ERR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((freeze || stall_act) && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_act && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
